// File: rtl/mod14_recombine.sv
// mod14_recombine: rebuilds value = quotient*MODULUS + residue by repeated
// addition of MODULUS, one add per cycle, with valid/ready on both sides.
// Illegal residues and results that do not fit in WIDTH bits raise out_err.
module mod14_recombine #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned QWIDTH  = 5,
    parameter int unsigned MODULUS = 14
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [QWIDTH-1:0] in_quot,
    input  logic [3:0]        in_res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_value,
    output logic              out_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] SAT_VALUE = '1;
    localparam logic [QWIDTH-1:0] CNT_ONE  = QWIDTH'(1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WIDTH:0]    acc;
    logic [WIDTH:0]    acc_nxt;
    logic [QWIDTH-1:0] cnt;
    logic [QWIDTH-1:0] cnt_nxt;
    logic              in_ready_nxt;
    logic              out_valid_nxt;
    logic [WIDTH-1:0]  out_value_nxt;
    logic              out_err_nxt;

    // One extra bit on the sum makes overflow a simple carry-out test.
    logic [WIDTH:0]    sum_c;
    logic              res_bad_c;

    assign sum_c     = acc + MOD_EXT;
    assign res_bad_c = (32'(in_res) >= MODULUS);

    // State, datapath and registered handshake/result outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_value <= '0;
            out_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_value <= out_value_nxt;
            out_err   <= out_err_nxt;
        end
    end

    // Next-state and next-output decode; everything holds unless a state acts.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        in_ready_nxt  = in_ready;
        out_valid_nxt = out_valid;
        out_value_nxt = out_value;
        out_err_nxt   = out_err;

        case (state)
            S_IDLE: begin
                in_ready_nxt  = 1'b1;
                out_valid_nxt = 1'b0;
                if (in_valid && in_ready) begin
                    in_ready_nxt = 1'b0;
                    if (res_bad_c) begin
                        // Illegal residue: report immediately, no accumulation.
                        out_valid_nxt = 1'b1;
                        out_value_nxt = '0;
                        out_err_nxt   = 1'b1;
                        state_nxt     = S_DONE;
                    end else begin
                        acc_nxt   = (WIDTH+1)'(in_res);
                        cnt_nxt   = in_quot;
                        state_nxt = S_ACCUM;
                    end
                end
            end

            S_ACCUM: begin
                in_ready_nxt = 1'b0;
                if (cnt == '0) begin
                    out_valid_nxt = 1'b1;
                    out_value_nxt = acc[WIDTH-1:0];
                    out_err_nxt   = 1'b0;
                    state_nxt     = S_DONE;
                end else if (sum_c[WIDTH]) begin
                    // Next add would not fit: saturate and skip the remainder.
                    out_valid_nxt = 1'b1;
                    out_value_nxt = SAT_VALUE;
                    out_err_nxt   = 1'b1;
                    state_nxt     = S_DONE;
                end else begin
                    acc_nxt = sum_c;
                    cnt_nxt = cnt - CNT_ONE;
                end
            end

            S_DONE: begin
                in_ready_nxt  = 1'b0;
                out_valid_nxt = 1'b1;
                if (out_ready) begin
                    // Result taken; IDLE for at least one cycle before next accept.
                    out_valid_nxt = 1'b0;
                    in_ready_nxt  = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end

            default: begin
                state_nxt     = S_IDLE;
                in_ready_nxt  = 1'b1;
                out_valid_nxt = 1'b0;
                out_value_nxt = '0;
                out_err_nxt   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mod14_recombine.sv
// Self-checking bench for mod14_recombine against an arithmetic reference model.
module tb_mod14_recombine;

    localparam int unsigned MOD  = 14;
    localparam int unsigned MAXV = 255;

    logic       clock;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_quot;
    logic [3:0] in_res;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_value;
    logic       out_err;

    int errors;
    int checks;

    mod14_recombine #(.WIDTH(8), .QWIDTH(5), .MODULUS(14)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_quot   (in_quot),
        .in_res    (in_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_err   (out_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: value, error flag and latency (accept edge counted as cycle 1).
    function automatic void model(input int q, input int r, output int val, output int err, output int lat);
        int full;
        if (r >= int'(MOD)) begin
            val = 0; err = 1; lat = 1;
        end else begin
            full = q * int'(MOD) + r;
            if (full <= int'(MAXV)) begin
                val = full; err = 0; lat = q + 2;
            end else begin
                // Adds that still fit before the one that would overflow.
                val = int'(MAXV); err = 1; lat = (int'(MAXV) - r) / int'(MOD) + 2;
            end
        end
    endfunction

    // Drive one pair and measure latency to out_valid; does no checking itself.
    task automatic send_measure(input int q, input int r, output int lat,
                                output logic [7:0] val, output logic err, output logic timed_out);
        int w;
        w = 0;
        timed_out = 1'b0;
        while (!in_ready && w < 100) begin
            @(posedge clock); #1; w++;
        end
        in_quot  = 5'(q);
        in_res   = 4'(r);
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clock); #1; lat++;
        end
        if (!out_valid) timed_out = 1'b1;
        val = out_value;
        err = out_err;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #23;
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_value !== 8'd0)   begin errors++; $display("FAIL reset_out_value got=%0d exp=0", out_value); end
        checks++; if (out_err !== 1'b0)     begin errors++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_min_quot();
        int lat, ev, ee, el;
        logic [7:0] v; logic e, to;
        out_ready = 1'b1;
        model(0, 13, ev, ee, el);
        send_measure(0, 13, lat, v, e, to);
        checks++; if (to)                begin errors++; $display("FAIL min_timeout got=timeout exp=out_valid"); end
        checks++; if (lat !== el)        begin errors++; $display("FAIL min_latency got=%0d exp=%0d", lat, el); end
        checks++; if (v !== 8'(ev))      begin errors++; $display("FAIL min_value got=%0d exp=%0d", v, ev); end
        checks++; if (e !== 1'(ee))      begin errors++; $display("FAIL min_err got=%b exp=%0d", e, ee); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL min_ready_in_done got=%b exp=0", in_ready); end
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL min_valid_after_hs got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL min_ready_after_hs got=%b exp=1", in_ready); end
    endtask

    task automatic test_saturate();
        int lat, ev, ee, el;
        logic [7:0] v; logic e, to;
        int rs [2] = '{3, 4};
        out_ready = 1'b1;
        foreach (rs[i]) begin
            model(18, rs[i], ev, ee, el);
            send_measure(18, rs[i], lat, v, e, to);
            checks++; if (to)           begin errors++; $display("FAIL sat_timeout r=%0d", rs[i]); end
            checks++; if (lat !== el)   begin errors++; $display("FAIL sat_latency r=%0d got=%0d exp=%0d", rs[i], lat, el); end
            checks++; if (v !== 8'(ev)) begin errors++; $display("FAIL sat_value r=%0d got=%0d exp=%0d", rs[i], v, ev); end
            checks++; if (e !== 1'(ee)) begin errors++; $display("FAIL sat_err r=%0d got=%b exp=%0d", rs[i], e, ee); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_illegal();
        int lat, ev, ee, el, q;
        logic [7:0] v; logic e, to;
        out_ready = 1'b1;
        for (int r = 14; r <= 15; r++) begin
            q = int'($urandom_range(31, 0));
            model(q, r, ev, ee, el);
            send_measure(q, r, lat, v, e, to);
            checks++; if (to)           begin errors++; $display("FAIL ill_timeout r=%0d", r); end
            checks++; if (lat !== el)   begin errors++; $display("FAIL ill_latency r=%0d got=%0d exp=%0d", r, lat, el); end
            checks++; if (v !== 8'(ev)) begin errors++; $display("FAIL ill_value r=%0d got=%0d exp=%0d", r, v, ev); end
            checks++; if (e !== 1'(ee)) begin errors++; $display("FAIL ill_err r=%0d got=%b exp=%0d", r, e, ee); end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat, ev, ee, el, extra;
        logic [7:0] v; logic e, to;
        out_ready = 1'b0;
        model(5, 7, ev, ee, el);
        send_measure(5, 7, lat, v, e, to);
        checks++; if (to)           begin errors++; $display("FAIL bp_timeout"); end
        checks++; if (v !== 8'(ev)) begin errors++; $display("FAIL bp_value got=%0d exp=%0d", v, ev); end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'($urandom_range(1, 0));
            in_quot  = 5'($urandom);
            in_res   = 4'($urandom);
            @(posedge clock); #1;
            checks++;
            if (out_valid !== 1'b1 || out_value !== 8'(ev) || out_err !== 1'(ee) || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got v=%b val=%0d err=%b rdy=%b exp v=1 val=%0d err=%0d rdy=0",
                         c, out_valid, out_value, out_err, in_ready, ev, ee);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            if (out_valid) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL bp_single_hs extra_valid_cycles=%0d exp=0", extra); end
    endtask

    task automatic test_reset_midop();
        int lat, ev, ee, el, w;
        logic [7:0] v; logic e, to;
        out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin @(posedge clock); #1; w++; end
        in_quot = 5'd20; in_res = 4'd0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_value !== 8'd0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL midop_async_reset got rdy=%b v=%b val=%0d err=%b exp rdy=1 v=0 val=0 err=0",
                     in_ready, out_valid, out_value, out_err);
        end
        #8;
        reset_n = 1'b1;
        @(posedge clock); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midop_stale_valid got=%b exp=0", out_valid); end
        model(1, 1, ev, ee, el);
        send_measure(1, 1, lat, v, e, to);
        checks++; if (to)           begin errors++; $display("FAIL midop_timeout"); end
        checks++; if (lat !== el)   begin errors++; $display("FAIL midop_latency got=%0d exp=%0d", lat, el); end
        checks++; if (v !== 8'(ev)) begin errors++; $display("FAIL midop_value got=%0d exp=%0d", v, ev); end
        checks++; if (e !== 1'(ee)) begin errors++; $display("FAIL midop_err got=%b exp=%0d", e, ee); end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        int qs [3] = '{2, 1, 0};
        int rs [3] = '{0, 13, 0};
        int vals[$];
        int errs[$];
        int idx, ev, ee, el;
        logic pre_acc, pre_ov, pre_err;
        logic [7:0] pre_val;
        out_ready = 1'b1;
        idx = 0;
        in_quot = 5'(qs[0]); in_res = 4'(rs[0]); in_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && vals.size() < 3; cyc++) begin
            pre_acc = in_valid && in_ready;
            pre_ov  = out_valid;
            pre_val = out_value;
            pre_err = out_err;
            @(posedge clock); #1;
            if (pre_ov) begin
                vals.push_back(int'(pre_val));
                errs.push_back(int'(pre_err));
            end
            if (pre_acc) begin
                idx++;
                if (idx < 3) begin
                    in_quot = 5'(qs[idx]); in_res = 4'(rs[idx]);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (vals.size() != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", vals.size()); end
        for (int i = 0; i < 3 && i < vals.size(); i++) begin
            model(qs[i], rs[i], ev, ee, el);
            checks++;
            if (vals[i] != ev || errs[i] != ee) begin
                errors++;
                $display("FAIL b2b_result idx=%0d got val=%0d err=%0d exp val=%0d err=%0d", i, vals[i], errs[i], ev, ee);
            end
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic test_random();
        int lat, ev, ee, el, q, r;
        logic [7:0] v; logic e, to;
        out_ready = 1'b1;
        for (int n = 0; n < 25; n++) begin
            q = int'($urandom_range(31, 0));
            r = int'($urandom_range(15, 0));
            model(q, r, ev, ee, el);
            send_measure(q, r, lat, v, e, to);
            checks++;
            if (to || lat != el || v !== 8'(ev) || e !== 1'(ee)) begin
                errors++;
                $display("FAIL rand q=%0d r=%0d got val=%0d err=%b lat=%0d to=%b exp val=%0d err=%0d lat=%0d",
                         q, r, v, e, lat, to, ev, ee, el);
            end
            @(posedge clock); #1;
            if ($urandom_range(1, 0) == 1) begin
                @(posedge clock); #1;
            end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_quot   = '0;
        in_res    = '0;
        out_ready = 1'b0;
        test_reset();
        test_min_quot();
        test_saturate();
        test_illegal();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
